// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level Tetris game sequencer.
//
// Walks the game through IDLE -> GENERATE_PIECE -> FALL -> LOCK -> CLEAR_ROW
// using pulse/done handshakes with the piece generator and the row-clear unit.
// It also keeps score, total lines, level, and the level-dependent gravity period.
//
// Optional feature macro: GAME_PAUSE_EN
//   When defined, this adds the pause_btn input and the PAUSE state.
//
// Ports:
//   clk            in   1   clock
//   rst_n          in   1   synchronous active-low reset
//   start_btn      in   1   start / restart pulse (IDLE and GAME_OVER only)
//   gen_done       in   1   piece generator finished spawning
//   spawn_blocked  in   1   spawn collision, qualified by gen_done
//   can_fall       in   1   active piece can move down one row
//   soft_drop      in   1   selects SOFT_PERIOD as the gravity period
//   clear_done     in   1   row-clear unit finished
//   pause_btn      in   1   pause toggle pulse (GAME_PAUSE_EN only)
//   lines_cleared  in   3   rows removed, qualified by clear_done
//   game_state     out  3   current state encoding
//   gen_req        out  1   spawn request pulse
//   fall_step      out  1   move-down pulse
//   lock_piece     out  1   merge-piece pulse
//   score          out 16   saturating score
//   lines          out 10   total lines, saturating at 999
//   level          out  4   level, saturating at 15
module game_flow_ctrl #(
    parameter int unsigned TICK_BASE       = 50_000_000,
    parameter int unsigned TICK_STEP       = 4_000_000,
    parameter int unsigned TICK_MIN        = 5_000_000,
    parameter int unsigned SOFT_PERIOD     = 2_500_000,
    parameter int unsigned LINES_PER_LEVEL = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        gen_done,
    input  logic        spawn_blocked,
    input  logic        can_fall,
    input  logic        soft_drop,
    input  logic        clear_done,
`ifdef GAME_PAUSE_EN
    input  logic        pause_btn,
`endif
    input  logic [2:0]  lines_cleared,
    output logic [2:0]  game_state,
    output logic        gen_req,
    output logic        fall_step,
    output logic        lock_piece,
    output logic [15:0] score,
    output logic [9:0]  lines,
    output logic [3:0]  level
);

    localparam int unsigned PER_MAX = (TICK_BASE > SOFT_PERIOD) ? TICK_BASE : SOFT_PERIOD;
    localparam int unsigned PER_W   = $clog2(PER_MAX + 1);
    localparam int unsigned PER_W1  = PER_W + 1;
    localparam int unsigned LTN_W   = $clog2(LINES_PER_LEVEL + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GEN       = 3'd1,
        S_FALL      = 3'd2,
        S_LOCK      = 3'd3,
        S_CLEAR     = 3'd4,
        S_GAME_OVER = 3'd5,
        S_PAUSE     = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic               gen_req_nxt, fall_step_nxt, lock_piece_nxt;
    logic [15:0]        score_nxt;
    logic [9:0]         lines_nxt;
    logic [3:0]         level_nxt;
    logic [LTN_W-1:0]   ltn_q, ltn_nxt;
    logic [PER_W-1:0]   period_q, period_nxt;
    logic [PER_W-1:0]   tick_q, tick_nxt;

    logic               pause_req;

`ifdef GAME_PAUSE_EN
    assign pause_req = pause_btn;
`else
    assign pause_req = 1'b0;
`endif

    assign game_state = state;

    // Gravity tick detection; the >= compare lets a soft_drop edge take effect at once.
    logic [PER_W-1:0] active_period;
    logic             tick_hit;
    always_comb begin
        active_period = soft_drop ? PER_W'(SOFT_PERIOD) : period_q;
        tick_hit      = ({1'b0, tick_q} + PER_W1'(1)) >= {1'b0, active_period};
    end

    // Level period = max(TICK_BASE - level*TICK_STEP, TICK_MIN), computed signed.
    logic signed [40:0] per_calc;
    always_comb begin
        per_calc   = $signed(41'(TICK_BASE)) - $signed(41'(level) * 41'(TICK_STEP));
        period_nxt = (per_calc < $signed(41'(TICK_MIN))) ? PER_W'(TICK_MIN) : PER_W'(per_calc);
    end

    // Scoring and level arithmetic for a completed row clear.
    logic [2:0]  n_eff;
    logic [9:0]  pts;
    logic [14:0] add_pts;
    logic [16:0] score_sum;
    logic [10:0] lines_sum;
    int          ltn_v;
    logic [3:0]  level_v;
    always_comb begin
        n_eff = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
        case (n_eff)
            3'd1:    pts = 10'd100;
            3'd2:    pts = 10'd300;
            3'd3:    pts = 10'd500;
            3'd4:    pts = 10'd800;
            default: pts = 10'd0;
        endcase
        add_pts   = 15'(pts) * (15'(level) + 15'd1);
        score_sum = 17'(score) + 17'(add_pts);
        lines_sum = 11'(lines) + 11'(n_eff);
        // At most a 4-line deficit, so five passes cover every multi-level jump.
        ltn_v   = int'(ltn_q) - int'(n_eff);
        level_v = level;
        for (int i = 0; i < 5; i++) begin
            if (ltn_v <= 0) begin
                ltn_v = ltn_v + int'(LINES_PER_LEVEL);
                if (level_v != 4'd15) begin
                    level_v = level_v + 4'd1;
                end
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        gen_req_nxt    = 1'b0;
        fall_step_nxt  = 1'b0;
        lock_piece_nxt = 1'b0;
        score_nxt      = score;
        lines_nxt      = lines;
        level_nxt      = level;
        ltn_nxt        = ltn_q;
        tick_nxt       = tick_q;

        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (start_btn) begin
                    state_nxt = S_GEN;
                    score_nxt = 16'd0;
                    lines_nxt = 10'd0;
                    level_nxt = 4'd0;
                    ltn_nxt   = LTN_W'(LINES_PER_LEVEL);
                end
            end
            S_GEN: begin
                if (gen_done) begin
                    if (spawn_blocked) begin
                        state_nxt = S_GAME_OVER;
                    end else begin
                        state_nxt = S_FALL;
                        tick_nxt  = '0;
                    end
                end
            end
            S_FALL: begin
                if (pause_req) begin
                    state_nxt = S_PAUSE;
                end else if (tick_hit) begin
                    tick_nxt = '0;
                    if (can_fall) begin
                        fall_step_nxt = 1'b1;
                    end else begin
                        state_nxt = S_LOCK;
                    end
                end else begin
                    tick_nxt = tick_q + PER_W'(1);
                end
            end
            S_LOCK: begin
                state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (clear_done) begin
                    state_nxt = S_GEN;
                    score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    lines_nxt = (lines_sum > 11'd999) ? 10'd999 : lines_sum[9:0];
                    level_nxt = level_v;
                    ltn_nxt   = LTN_W'(ltn_v);
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (pause_req) begin
                    state_nxt = S_FALL;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Handshake pulses coincide with the first cycle of their state.
        gen_req_nxt    = (state_nxt == S_GEN) && (state != S_GEN);
        lock_piece_nxt = (state_nxt == S_LOCK) && (state != S_LOCK);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gen_req    <= 1'b0;
            fall_step  <= 1'b0;
            lock_piece <= 1'b0;
            score      <= 16'd0;
            lines      <= 10'd0;
            level      <= 4'd0;
            ltn_q      <= LTN_W'(LINES_PER_LEVEL);
            period_q   <= PER_W'(TICK_BASE);
            tick_q     <= '0;
        end else begin
            gen_req    <= gen_req_nxt;
            fall_step  <= fall_step_nxt;
            lock_piece <= lock_piece_nxt;
            score      <= score_nxt;
            lines      <= lines_nxt;
            level      <= level_nxt;
            ltn_q      <= ltn_nxt;
            period_q   <= period_nxt;
            tick_q     <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed testbench for game_flow_ctrl, using small test-plan parameters.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_btn;
    logic        gen_done;
    logic        spawn_blocked;
    logic        can_fall;
    logic        soft_drop;
    logic        clear_done;
    logic [2:0]  lines_cleared;
    logic [2:0]  game_state;
    logic        gen_req;
    logic        fall_step;
    logic        lock_piece;
    logic [15:0] score;
    logic [9:0]  lines;
    logic [3:0]  level;
`ifdef GAME_PAUSE_EN
    logic        pause_btn = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .TICK_BASE      (8),
        .TICK_STEP      (2),
        .TICK_MIN       (3),
        .SOFT_PERIOD    (2),
        .LINES_PER_LEVEL(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_btn    (start_btn),
        .gen_done     (gen_done),
        .spawn_blocked(spawn_blocked),
        .can_fall     (can_fall),
        .soft_drop    (soft_drop),
        .clear_done   (clear_done),
`ifdef GAME_PAUSE_EN
        .pause_btn    (pause_btn),
`endif
        .lines_cleared(lines_cleared),
        .game_state   (game_state),
        .gen_req      (gen_req),
        .fall_step    (fall_step),
        .lock_piece   (lock_piece),
        .score        (score),
        .lines        (lines),
        .level        (level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count the edges until the next fall_step pulse, with a bounded wait.
    task automatic wait_fall(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!fall_step && cnt < 50);
    endtask

    // Count the edges until game_state reaches target, with a bounded wait.
    task automatic wait_state(input logic [2:0] target, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (game_state != target && cnt < 50);
    endtask

    task automatic pulse_gen_done(input logic blocked);
        gen_done = 1'b1;
        spawn_blocked = blocked;
        step();
        gen_done = 1'b0;
        spawn_blocked = 1'b0;
    endtask

    task automatic pulse_clear(input logic [2:0] nl);
        clear_done = 1'b1;
        lines_cleared = nl;
        step();
        clear_done = 1'b0;
        lines_cleared = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0; start_btn = 1'b0; gen_done = 1'b0; spawn_blocked = 1'b0;
        can_fall = 1'b0; soft_drop = 1'b0; clear_done = 1'b0; lines_cleared = 3'd0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_state", 32'(game_state), 0);
        check("rst_outs", {gen_req, fall_step, lock_piece}, 0);
        check("rst_score", 32'(score), 0);
        check("rst_lines_level", {lines, level}, 0);

        // Start the game: one-cycle gen_req in the same cycle as GENERATE_PIECE
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        check("start_state", 32'(game_state), 1);
        check("start_gen_req", 32'(gen_req), 1);
        step();
        check("gen_req_drop", 32'(gen_req), 0);
        check("gen_wait_state", 32'(game_state), 1);

        // Gravity at the level-0 period of 8
        can_fall = 1'b1;
        pulse_gen_done(1'b0);
        check("fall_state", 32'(game_state), 2);
        wait_fall(n);
        check("grav_first", n, 8);
        wait_fall(n);
        check("grav_period", n, 8);

        // Soft drop gives a period of 2
        soft_drop = 1'b1;
        wait_fall(n);
        check("soft_first", n, 2);
        wait_fall(n);
        check("soft_period", n, 2);
        soft_drop = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("no_tick_mid", 32'(fall_step), 0);
        soft_drop = 1'b1;
        wait_fall(n);
        check("soft_edge_immediate", n, 1);
        soft_drop = 1'b0;

        // can_fall low at the tick leads to LOCK and then CLEAR_ROW
        can_fall = 1'b0;
        wait_state(3'd3, n);
        check("lock_after", n, 8);
        check("lock_pulse", 32'(lock_piece), 1);
        step();
        check("clear_state", 32'(game_state), 4);
        check("lock_one_cycle", 32'(lock_piece), 0);

        // In CLEAR_ROW, start_btn and gen_done are ignored
        start_btn = 1'b1; gen_done = 1'b1;
        step();
        start_btn = 1'b0; gen_done = 1'b0;
        check("clear_ignores", 32'(game_state), 4);

        // Clearing 4 lines at level 0 scores 800 and advances two levels
        pulse_clear(3'd4);
        check("c4_state", 32'(game_state), 1);
        check("c4_gen_req", 32'(gen_req), 1);
        check("c4_score", 32'(score), 800);
        check("c4_lines", 32'(lines), 4);
        check("c4_level", 32'(level), 2);

        // The level-2 period is 4
        can_fall = 1'b1;
        pulse_gen_done(1'b0);
        wait_fall(n);
        check("lvl2_period", n, 4);
        can_fall = 1'b0;
        wait_state(3'd3, n);
        check("lvl2_lock", n, 4);
        step();

        // 3 lines at level 2 add 1500 and advance to level 3
        pulse_clear(3'd3);
        check("c3_score", 32'(score), 2300);
        check("c3_lines", 32'(lines), 7);
        check("c3_level", 32'(level), 3);

        // The level-3 period clamps to TICK_MIN = 3
        can_fall = 1'b1;
        pulse_gen_done(1'b0);
        wait_fall(n);
        check("lvl3_period", n, 3);
        can_fall = 1'b0;
        wait_state(3'd3, n);
        check("lvl3_lock", n, 3);
        step();

        // lines_cleared = 7 counts as 4: 800*4 = 3200 added, level 3 -> 5
        pulse_clear(3'd7);
        check("c7_score", 32'(score), 5500);
        check("c7_lines", 32'(lines), 11);
        check("c7_level", 32'(level), 5);

        // A blocked spawn ends the game and the counters hold
        pulse_gen_done(1'b1);
        check("over_state", 32'(game_state), 5);
        clear_done = 1'b1; lines_cleared = 3'd4; gen_done = 1'b1;
        step(); step();
        clear_done = 1'b0; lines_cleared = 3'd0; gen_done = 1'b0;
        check("over_hold_state", 32'(game_state), 5);
        check("over_hold_score", 32'(score), 5500);
        check("over_hold_lines", {lines, level}, {10'd11, 4'd5});

        // Restart from GAME_OVER clears the counters
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        check("restart_state", 32'(game_state), 1);
        check("restart_counters", {score, lines, level}, 0);
        check("restart_gen_req", 32'(gen_req), 1);

        // Reset in the middle of CLEAR_ROW
        step();
        pulse_gen_done(1'b0);
        wait_state(3'd3, n);
        check("rst_mid_lock", n, 8);
        step();
        check("rst_mid_in_clear", 32'(game_state), 4);
        rst_n = 1'b0;
        step();
        check("rst_mid_state", 32'(game_state), 0);
        check("rst_mid_outs", {gen_req, fall_step, lock_piece}, 0);
        rst_n = 1'b1;
        pulse_clear(3'd2);
        check("late_clear_state", 32'(game_state), 0);
        check("late_clear_counters", {score, lines, level}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
